// File: rtl/xcorr_window_feeder.sv
// xcorr_window_feeder
// Producer side of the sliding-window cross-correlation accumulator.
// Each accepted (f, g) pair shifts the f/g delay lines. It also loads one
// cycle of add/sub operands so the accumulator adds the product entering the
// window and removes the product leaving it, for every lag -D..+D.
// Operands are zero on every cycle without an accepted pair. This lets the
// free-running accumulator (width 2*NUM_BITS_SAMPLE + clog2(N)) hold its value.
module xcorr_window_feeder #(
  parameter int NUM_BITS_SAMPLE   = 12,
  parameter int NUM_SAMPLES       = 100,
  parameter int MAX_SAMPLES_DELAY = 11
) (
  input  logic                                                    clk,
  input  logic                                                    rst,
  input  logic [NUM_BITS_SAMPLE-1:0]                              in_f,
  input  logic [NUM_BITS_SAMPLE-1:0]                              in_g,
  input  logic                                                    in_valid,
  output logic                                                    in_ready,
  input  logic                                                    hold,
  output logic [NUM_BITS_SAMPLE-1:0]                              add_f,
  output logic [NUM_BITS_SAMPLE-1:0]                              sub_f,
  output logic [(2*MAX_SAMPLES_DELAY+1)*NUM_BITS_SAMPLE-1:0]      add_g,
  output logic [(2*MAX_SAMPLES_DELAY+1)*NUM_BITS_SAMPLE-1:0]      sub_g,
  output logic                                                    step,
  output logic                                                    xcorr_valid,
  output logic                                                    window_full
);

  localparam int NB     = NUM_BITS_SAMPLE;
  localparam int N      = NUM_SAMPLES;
  localparam int D      = MAX_SAMPLES_DELAY;
  localparam int NLAGS  = 2 * D + 1;
  localparam int GW     = NLAGS * NB;
  // The oldest sample needed is consumed straight out of the pre-shift
  // history at the accept edge, so each line is one entry shorter than the
  // number of distinct ages it exposes.
  localparam int FDEPTH = D + N;
  localparam int GDEPTH = 2 * D + N;
  localparam int CNT_W  = $clog2(N + 2 * D + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(N + 2 * D);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_FULL = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NB-1:0]     fh_q [FDEPTH];
  logic [NB-1:0]     gh_q [GDEPTH];

  logic [NB-1:0]     add_f_q, add_f_d, sub_f_q, sub_f_d;
  logic [GW-1:0]     add_g_q, add_g_d, sub_g_q, sub_g_d;
  logic              step_q, window_full_q, xcorr_valid_q;

  logic              accept_s;
  logic [NB-1:0]     add_f_sel_s, sub_f_sel_s;
  logic [GW-1:0]     add_g_sel_s, sub_g_sel_s;

  // Reset removes readiness immediately so nothing is accepted while clearing.
  assign in_ready = !hold && !rst;
  assign accept_s = in_valid && in_ready;

  // Operand taps: age k of the extended line is the new sample for k = 0,
  // otherwise pre-shift history entry k-1.
  generate
    if (D == 0) begin : g_f_new
      assign add_f_sel_s = in_f;
    end else begin : g_f_hist
      assign add_f_sel_s = fh_q[D-1];
    end
    assign sub_f_sel_s = fh_q[D+N-1];

    for (genvar d = 0; d < NLAGS; d++) begin : g_lag
      if (d == 2 * D) begin : g_add_new
        assign add_g_sel_s[d*NB +: NB] = in_g;
      end else begin : g_add_hist
        assign add_g_sel_s[d*NB +: NB] = gh_q[2*D-d-1];
      end
      assign sub_g_sel_s[d*NB +: NB] = gh_q[2*D-d+N-1];
    end
  endgenerate

  // Shift both delay lines by one position on every accepted pair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < FDEPTH; k++) fh_q[k] <= '0;
      for (int k = 0; k < GDEPTH; k++) gh_q[k] <= '0;
    end else if (accept_s) begin
      fh_q[0] <= in_f;
      gh_q[0] <= in_g;
      for (int k = 1; k < FDEPTH; k++) fh_q[k] <= fh_q[k-1];
      for (int k = 1; k < GDEPTH; k++) gh_q[k] <= gh_q[k-1];
    end
  end

  // Next operand values: the selected taps on an accept, zero otherwise.
  always_comb begin
    add_f_d = '0;
    sub_f_d = '0;
    add_g_d = '0;
    sub_g_d = '0;
    if (accept_s) begin
      add_f_d = add_f_sel_s;
      sub_f_d = sub_f_sel_s;
      add_g_d = add_g_sel_s;
      sub_g_d = sub_g_sel_s;
    end else begin
      add_f_d = '0;
      sub_f_d = '0;
      add_g_d = '0;
      sub_g_d = '0;
    end
  end

  // Fill-state machine and saturating accepted-pair counter: next state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          cnt_d   = CNT_ONE;
          state_d = (CNT_FULL == CNT_ONE) ? S_FULL : S_FILL;
        end else begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      S_FILL: begin
        if (accept_s) begin
          cnt_d   = cnt_q + CNT_ONE;
          state_d = ((cnt_q + CNT_ONE) == CNT_FULL) ? S_FULL : S_FILL;
        end else begin
          cnt_d   = cnt_q;
          state_d = S_FILL;
        end
      end
      S_FULL: begin
        cnt_d   = CNT_FULL;
        state_d = S_FULL;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      add_f_q       <= '0;
      sub_f_q       <= '0;
      add_g_q       <= '0;
      sub_g_q       <= '0;
      step_q        <= 1'b0;
      window_full_q <= 1'b0;
      xcorr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      add_f_q       <= add_f_d;
      sub_f_q       <= sub_f_d;
      add_g_q       <= add_g_d;
      sub_g_q       <= sub_g_d;
      step_q        <= accept_s;
      window_full_q <= (state_d == S_FULL);
      // The accumulator consumes step at this edge; its result covers a full
      // window only if the window was already full after the accept edge.
      xcorr_valid_q <= step_q && window_full_q;
    end
  end

  assign add_f       = add_f_q;
  assign sub_f       = sub_f_q;
  assign add_g       = add_g_q;
  assign sub_g       = sub_g_q;
  assign step        = step_q;
  assign window_full = window_full_q;
  assign xcorr_valid = xcorr_valid_q;

endmodule
